// File: rtl/screen_raster_drawer.sv
// Full-frame raster painter: sweeps every pixel once per trigger and reads the selected
// image ROM. ROM data is plotted after the read latency, with (x, y) delayed to line up.
module screen_raster_drawer #(
    parameter int unsigned H_PIXELS    = 160,
    parameter int unsigned V_PIXELS    = 120,
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned COLOUR_W    = 3,
    parameter int unsigned NUM_SCREENS = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                            CLOCK_50,
    input  logic                            RESET,
    input  logic                            START,
    input  logic [SEL_W-1:0]                SCREEN,
    input  logic                            CONTINUOUS,
    output logic [Y_W+X_W-1:0]              ROM_ADDR,
    input  logic [NUM_SCREENS*COLOUR_W-1:0] ROM_DATA,
    output logic [X_W-1:0]                  VGA_X,
    output logic [Y_W-1:0]                  VGA_Y,
    output logic [COLOUR_W-1:0]             COLOUR,
    output logic                            PLOT,
    output logic                            BUSY,
    output logic                            DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_FLUSH
    } state_t;

    state_t               state_q;
    logic [X_W-1:0]       xc_q;
    logic [Y_W-1:0]       yc_q;
    logic [SEL_W-1:0]     cur_sel_q;
    logic                 pending_q;
    logic [1:0]           flush_cnt_q;
    logic                 done_q;
    logic                 valid_q [ROM_LATENCY];
    logic [X_W-1:0]       xp_q    [ROM_LATENCY];
    logic [Y_W-1:0]       yp_q    [ROM_LATENCY];

    logic                 trigger_d;
    logic                 request_d;
    logic                 last_col_d;
    logic                 last_pixel_d;
    logic                 flush_last_d;
    logic [COLOUR_W-1:0]  colour_d;

    assign request_d    = START | (SCREEN != cur_sel_q);
    assign trigger_d    = request_d | pending_q | CONTINUOUS;
    assign last_col_d   = (xc_q == X_W'(H_PIXELS - 1));
    assign last_pixel_d = last_col_d && (yc_q == Y_W'(V_PIXELS - 1));
    assign flush_last_d = (flush_cnt_q == 2'(ROM_LATENCY - 1));

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            xc_q        <= '0;
            yc_q        <= '0;
            cur_sel_q   <= '0;
            pending_q   <= 1'b1;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
            // NOTE: the alignment pipeline is reset on purpose so in-flight pixels are
            // dropped and PLOT falls the very next cycle.
            for (int i = 0; i < int'(ROM_LATENCY); i++) begin
                valid_q[i] <= 1'b0;
                xp_q[i]    <= '0;
                yp_q[i]    <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            valid_q[0] <= (state_q == S_SWEEP);
            xp_q[0]    <= xc_q;
            yp_q[0]    <= yc_q;
            for (int i = 1; i < int'(ROM_LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                xp_q[i]    <= xp_q[i-1];
                yp_q[i]    <= yp_q[i-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (trigger_d) begin
                        cur_sel_q <= SCREEN;
                        pending_q <= 1'b0;
                        xc_q      <= '0;
                        yc_q      <= '0;
                        state_q   <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (request_d) pending_q <= 1'b1;
                    // Counters park at (0,0) so no address past the last pixel is issued.
                    if (last_pixel_d) begin
                        xc_q        <= '0;
                        yc_q        <= '0;
                        flush_cnt_q <= '0;
                        state_q     <= S_FLUSH;
                    end else if (last_col_d) begin
                        xc_q <= '0;
                        yc_q <= yc_q + 1'b1;
                    end else begin
                        xc_q <= xc_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_last_d) begin
                        done_q <= 1'b1;
                        if (trigger_d) begin
                            cur_sel_q <= SCREEN;
                            pending_q <= 1'b0;
                            state_q   <= S_SWEEP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                        if (request_d) pending_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Out-of-range selections fall through to zero while PLOT still pulses.
    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        colour_d = '0;
        for (int k = 0; k < int'(NUM_SCREENS); k++) begin
            if (PLOT && (cur_sel_q == SEL_W'(k))) colour_d = ROM_DATA[k*COLOUR_W +: COLOUR_W];
        end
    end

    assign ROM_ADDR = {yc_q, xc_q};
    assign PLOT     = valid_q[ROM_LATENCY-1];
    assign VGA_X    = xp_q[ROM_LATENCY-1];
    assign VGA_Y    = yp_q[ROM_LATENCY-1];
    assign COLOUR   = colour_d;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;

endmodule

// File: tb/tb_screen_raster_drawer.sv
// Bench for screen_raster_drawer: two instances (ROM latency 1 and 2) share stimulus and
// are checked every cycle against a frame-schedule model, plus literal pins.
module tb_screen_raster_drawer;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int N  = H * V;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int CW = 3;
    localparam int NS = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] screen = '0;
    logic          cont = 1'b0;
    int            rom_mode = 0;

    logic [YW+XW-1:0] addr  [2];
    logic [NS*CW-1:0] rdata [2];
    logic [NS*CW-1:0] rom1_s1;
    logic [XW-1:0]    vx    [2];
    logic [YW-1:0]    vy    [2];
    logic [CW-1:0]    col   [2];
    logic             plot  [2];
    logic             busy  [2];
    logic             done  [2];

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    screen_raster_drawer #(
        .H_PIXELS(H), .V_PIXELS(V), .X_W(XW), .Y_W(YW), .COLOUR_W(CW),
        .NUM_SCREENS(NS), .SEL_W(SW), .ROM_LATENCY(1)
    ) dut0 (
        .CLOCK_50(clk), .RESET(rst), .START(start), .SCREEN(screen), .CONTINUOUS(cont),
        .ROM_ADDR(addr[0]), .ROM_DATA(rdata[0]), .VGA_X(vx[0]), .VGA_Y(vy[0]),
        .COLOUR(col[0]), .PLOT(plot[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    screen_raster_drawer #(
        .H_PIXELS(H), .V_PIXELS(V), .X_W(XW), .Y_W(YW), .COLOUR_W(CW),
        .NUM_SCREENS(NS), .SEL_W(SW), .ROM_LATENCY(2)
    ) dut1 (
        .CLOCK_50(clk), .RESET(rst), .START(start), .SCREEN(screen), .CONTINUOUS(cont),
        .ROM_ADDR(addr[1]), .ROM_DATA(rdata[1]), .VGA_X(vx[1]), .VGA_Y(vy[1]),
        .COLOUR(col[1]), .PLOT(plot[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    // Image content: mode 0 paints channel index k, mode 1 varies per pixel.
    function automatic int rom_val(input int mode, input int k, input int x, input int y);
        return (mode == 0) ? k : (k + x + 2 * y) % 8;
    endfunction

    function automatic logic [NS*CW-1:0] rom_word(input int mode, input logic [YW+XW-1:0] a);
        logic [NS*CW-1:0] w;
        w = '0;
        for (int k = 0; k < NS; k++) w[k*CW +: CW] = CW'(rom_val(mode, k, int'(a[XW-1:0]), int'(a[YW+XW-1:XW])));
        return w;
    endfunction

    always @(posedge clk) begin
        rdata[0] <= rom_word(rom_mode, addr[0]);
        rom1_s1  <= rom_word(rom_mode, addr[1]);
        rdata[1] <= rom1_s1;
    end

    task automatic check(input string name, input int got, input int exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Model: each frame is a start cycle s; addresses run s+1..s+N, plots s+1+L..s+N+L,
    // the trigger is re-evaluated at s+N+L and DONE appears one cycle later.
    int cyc = 0;
    bit started = 0;
    bit m_active [2];
    int m_s      [2];
    int m_sel    [2];
    bit m_pend   [2];
    bit e_plot [2], e_done [2], e_busy [2];
    int e_x [2], e_y [2], e_col [2], e_addr [2];
    int lat, nx, idx, ai;
    bit trig, done_now;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            lat      = d + 1;
            nx       = cyc + 1;
            done_now = 0;
            trig     = start || m_pend[d] || cont || (int'(screen) != m_sel[d]);
            if (rst) begin
                m_active[d] = 0;
                m_pend[d]   = 1;
                m_sel[d]    = 0;
            end else if (!m_active[d]) begin
                if (trig) begin
                    m_active[d] = 1; m_s[d] = cyc; m_sel[d] = int'(screen); m_pend[d] = 0;
                end
            end else if (cyc == m_s[d] + N + lat) begin
                done_now = 1;
                if (trig) begin
                    m_s[d] = cyc; m_sel[d] = int'(screen); m_pend[d] = 0;
                end else begin
                    m_active[d] = 0;
                end
            end else if (start || int'(screen) != m_sel[d]) begin
                m_pend[d] = 1;
            end
            e_done[d] = done_now;
            e_busy[d] = m_active[d];
            idx       = nx - (m_s[d] + 1 + lat);
            e_plot[d] = m_active[d] && idx >= 0 && idx < N;
            e_x[d]    = e_plot[d] ? idx % H : 0;
            e_y[d]    = e_plot[d] ? idx / H : 0;
            e_col[d]  = e_plot[d] ? rom_val(rom_mode, m_sel[d], e_x[d], e_y[d]) : 0;
            ai        = nx - (m_s[d] + 1);
            e_addr[d] = (m_active[d] && ai >= 0 && ai < N) ? (ai / H) * (1 << XW) + ai % H : 0;
        end
        cyc++;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d_plot@%0d", d, cyc), int'(plot[d]), int'(e_plot[d]));
                if (e_plot[d]) begin
                    check($sformatf("d%0d_x@%0d", d, cyc), int'(vx[d]), e_x[d]);
                    check($sformatf("d%0d_y@%0d", d, cyc), int'(vy[d]), e_y[d]);
                    check($sformatf("d%0d_colour@%0d", d, cyc), int'(col[d]), e_col[d]);
                end
                check($sformatf("d%0d_done@%0d", d, cyc), int'(done[d]), int'(e_done[d]));
                check($sformatf("d%0d_busy@%0d", d, cyc), int'(busy[d]), int'(e_busy[d]));
                check($sformatf("d%0d_addr@%0d", d, cyc), int'(addr[d]), e_addr[d]);
            end
        end
    end

    task automatic tick(inout int p, inout int dn, inout int hits, input int want_col);
        @(negedge clk);
        p  += int'(plot[0]);
        dn += int'(done[0]);
        if (plot[0] && int'(col[0]) == want_col) hits++;
    endtask

    task automatic run_to_idle(inout int p, inout int dn, inout int hits, input int want_col);
        int i;
        for (i = 0; i < 300; i++) begin
            tick(p, dn, hits, want_col);
            if (!busy[0] && !busy[1] && !plot[0] && !plot[1]) break;
        end
        check("idle_reached", int'(i < 300), 1);
    endtask

    initial begin
        int p, dn, hits, k;

        // Auto frame after reset; literal timing pins for both latencies.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        p = 0; dn = 0; hits = 0;
        for (k = 1; k <= 15; k++) begin
            tick(p, dn, hits, 0);
            if (k == 1)  begin check("c1_plot0", int'(plot[0]), 0); check("c1_busy0", int'(busy[0]), 1); end
            if (k == 2)  begin check("c2_plot0", int'(plot[0]), 1); check("c2_xy0", int'({vx[0], vy[0]}), 0);
                               check("c2_plot1", int'(plot[1]), 0); end
            if (k == 3)  begin check("c3_plot1", int'(plot[1]), 1); check("c3_x1", int'(vx[1]), 0); end
            if (k == 13) begin check("c13_x0", int'(vx[0]), 3); check("c13_y0", int'(vy[0]), 2);
                               check("c13_done0", int'(done[0]), 0); end
            if (k == 14) begin check("c14_plot0", int'(plot[0]), 0); check("c14_done0", int'(done[0]), 1);
                               check("c14_busy0", int'(busy[0]), 0); end
            if (k == 15) begin check("c15_done0", int'(done[0]), 0); check("c15_done1", int'(done[1]), 1); end
        end
        check("auto_plots", p, 12);
        check("auto_dones", dn, 1);
        check("auto_colour0", hits, 12);

        // Screen 2 selected while idle.
        screen = 2'd2;
        p = 0; dn = 0; hits = 0;
        run_to_idle(p, dn, hits, 2);
        check("s2_plots", p, 12);
        check("s2_dones", dn, 1);
        check("s2_colour2", hits, 12);

        // Screen 1 frame, switch to 3 at the 5th plot.
        screen = 2'd1;
        p = 0; dn = 0; hits = 0;
        for (k = 0; k < 50 && p < 5; k++) tick(p, dn, hits, 1);
        check("sw_5th_plot", p, 5);
        screen = 2'd3;
        for (k = 0; k < 50 && dn == 0; k++) tick(p, dn, hits, 1);
        check("sw_first_colour1", hits, 12);
        check("sw_b2b_busy", int'(busy[0]), 1);
        p = 0; dn = 0; hits = 0;
        run_to_idle(p, dn, hits, 3);
        check("sw_second_plots", p, 12);
        check("sw_second_colour3", hits, 12);
        check("sw_second_dones", dn, 1);

        // Continuous for three frames with per-pixel colours.
        rom_mode = 1;
        cont = 1'b1;
        p = 0; dn = 0; hits = 0;
        for (k = 0; k < 200 && dn < 2; k++) tick(p, dn, hits, -1);
        hits = p;
        for (k = 0; k < 50 && p < hits + 3; k++) tick(p, dn, hits, -1);
        cont = 1'b0;
        run_to_idle(p, dn, hits, -1);
        check("cont_plots", p, 36);
        check("cont_dones", dn, 3);

        // START together with a screen change while idle: one frame.
        screen = 2'd0;
        start  = 1'b1;
        p = 0; dn = 0; hits = 0;
        tick(p, dn, hits, -1);
        start = 1'b0;
        run_to_idle(p, dn, hits, -1);
        check("startsel_plots", p, 12);
        check("startsel_dones", dn, 1);

        // Requests mid-frame collapse into one extra frame.
        start = 1'b1;
        p = 0; dn = 0; hits = 0;
        tick(p, dn, hits, -1);
        start = 1'b0;
        repeat (3) tick(p, dn, hits, -1);
        start = 1'b1;
        tick(p, dn, hits, -1);
        start  = 1'b0;
        screen = 2'd1;
        repeat (2) tick(p, dn, hits, -1);
        screen = 2'd0;
        tick(p, dn, hits, -1);
        start = 1'b1;
        tick(p, dn, hits, -1);
        start = 1'b0;
        run_to_idle(p, dn, hits, -1);
        check("collapse_plots", p, 24);
        check("collapse_dones", dn, 2);

        // Reset at the 7th plot.
        start = 1'b1;
        p = 0; dn = 0; hits = 0;
        tick(p, dn, hits, -1);
        start = 1'b0;
        for (k = 0; k < 50 && p < 7; k++) tick(p, dn, hits, -1);
        check("rst_7th_plot", p, 7);
        rst = 1'b1;
        tick(p, dn, hits, -1);
        rst = 1'b0;
        check("rst_plot_low", int'(plot[0]), 0);
        check("rst_busy_low", int'(busy[0]), 0);
        p = 0; dn = 0; hits = 0;
        run_to_idle(p, dn, hits, -1);
        check("rst_restart_plots", p, 12);
        check("rst_restart_dones", dn, 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
